// File: rtl/inv_sub_bytes_engine.sv
// AES-128 InvSubBytes engine: applies the inverse S-box to a 128-bit state, LANES bytes per cycle.
// Optional macro AES_SBOX_BIDIR_EN adds a MODE input selecting forward (1) or inverse (0) S-box.
module inv_sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA
`ifdef AES_SBOX_BIDIR_EN
    ,
    input  logic         MODE
`endif
);

    localparam int N  = 16 / LANES;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("inv_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // Entry x lives at bits [8*(255-x) +: 8], i.e. entry 0x00 is the most significant byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

`ifdef AES_SBOX_BIDIR_EN
    localparam logic [2047:0] FWD_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic mode_q;

    function automatic logic [7:0] lookup(input logic [7:0] b, input logic fwd);
        return fwd ? FWD_SBOX[8*(255 - int'(b)) +: 8] : INV_SBOX[8*(255 - int'(b)) +: 8];
    endfunction
`else
    function automatic logic [7:0] lookup(input logic [7:0] b);
        return INV_SBOX[8*(255 - int'(b)) +: 8];
    endfunction
`endif

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t          state;
    logic [GW-1:0]   grp;
    logic [127:0]    work;
    logic [127:0]    sub_next;
    logic            out_valid_q;

    // Substitute the bytes of the current group; every other byte passes through.
    always_comb begin
        sub_next = work;
        for (int j = 0; j < LANES; j++) begin
`ifdef AES_SBOX_BIDIR_EN
            sub_next[127 - 8*(int'(grp)*LANES + j) -: 8] =
                lookup(work[127 - 8*(int'(grp)*LANES + j) -: 8], mode_q);
`else
            sub_next[127 - 8*(int'(grp)*LANES + j) -: 8] =
                lookup(work[127 - 8*(int'(grp)*LANES + j) -: 8]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grp         <= '0;
            work        <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_SBOX_BIDIR_EN
            mode_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID && IN_READY) begin
                        work  <= IN_DATA;
                        grp   <= '0;
                        state <= SUB;
`ifdef AES_SBOX_BIDIR_EN
                        mode_q <= MODE;
`endif
                    end
                end
                SUB: begin
                    work <= sub_next;
                    if (grp == GW'(N - 1)) begin
                        grp         <= '0;
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        grp <= grp + 1'b1;
                    end
                end
                DONE: begin
                    if (OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign IN_READY  = (state == IDLE) && !rst;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = work;

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// Self-checking bench for inv_sub_bytes_engine at LANES = 4, 16, 1 and 2.
// Expected values come from an S-box built here from GF(2^8) inversion plus the affine map.
module tb_inv_sub_bytes_engine;

    localparam int LANES_TAB [4] = '{4, 16, 1, 2};
    localparam int D4 = 0, D16 = 1, D1 = 2, D2 = 3;

    logic         clk;
    logic         rst;
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [127:0] in_data   [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [127:0] out_data  [4];
`ifdef AES_SBOX_BIDIR_EN
    logic         mode      [4];
`endif

    int checks;
    int errors;

    logic [7:0] sbox_fwd [256];
    logic [7:0] sbox_inv [256];

    for (genvar k = 0; k < 4; k++) begin : g_dut
        inv_sub_bytes_engine #(.LANES(LANES_TAB[k])) dut (
            .clk      (clk),
            .rst      (rst),
            .IN_VALID (in_valid[k]),
            .IN_READY (in_ready[k]),
            .IN_DATA  (in_data[k]),
            .OUT_VALID(out_valid[k]),
            .OUT_READY(out_ready[k]),
            .OUT_DATA (out_data[k])
`ifdef AES_SBOX_BIDIR_EN
            ,
            .MODE     (mode[k])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_fwd[x] = s;
            sbox_inv[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] d);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_inv[d[127 - 8*i -: 8]];
        return r;
    endfunction

    // Waits (bounded) for IN_READY, then presents one block for exactly one accepting edge.
    task automatic send(input int k, input logic [127:0] data, input string name);
        int w;
        w = 0;
        while (in_ready[k] !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        checks++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s in_ready: got %b, expected 1", name, in_ready[k]);
        end
        in_valid[k] = 1'b1;
        in_data[k]  = data;
        tick();
        in_valid[k] = 1'b0;
        in_data[k]  = ~data;
`ifdef AES_SBOX_BIDIR_EN
        mode[k] = ~mode[k];
`endif
    endtask

    task automatic run_block(input int k, input logic [127:0] data, input int lat,
                             input string name, output logic [127:0] got);
        int cyc;
        send(k, data, name);
        cyc = 0;
        while (out_valid[k] !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc != lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d cycles, expected %0d", name, cyc, lat);
        end
        got = out_data[k];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checks += 3;
            if (out_valid[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset out_valid[%0d]: got %b, expected 0", k, out_valid[k]);
            end
            if (out_data[k] !== 128'h0) begin
                errors++;
                $display("[TB] FAIL reset out_data[%0d]: got %h, expected 0", k, out_data[k]);
            end
            if (in_ready[k] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset in_ready[%0d]: got %b, expected 0", k, in_ready[k]);
            end
        end
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL post-reset in_ready[%0d]: got %b, expected 1", k, in_ready[k]);
            end
        end
    endtask

    task automatic test_single_block();
        logic [127:0] got;
        out_ready[D4] = 1'b1;
        run_block(D4, 128'h637c777bf26b6fc53001672bfed7ab76, 4, "single", got);
        checks++;
        if (got !== 128'h000102030405060708090a0b0c0d0e0f) begin
            errors++;
            $display("[TB] FAIL single data: got %h, expected 000102030405060708090a0b0c0d0e0f", got);
        end
        tick();
        checks += 2;
        if (out_valid[D4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single out_valid after handshake: got %b, expected 0", out_valid[D4]);
        end
        if (in_ready[D4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single in_ready after handshake: got %b, expected 1", in_ready[D4]);
        end
    endtask

    task automatic test_table();
        logic [127:0] din;
        logic [127:0] got;
        logic [7:0]   res [256];
        logic [7:0]   spot_in  [4];
        logic [7:0]   spot_out [4];
        spot_in  = '{8'h00, 8'h52, 8'h16, 8'h63};
        spot_out = '{8'h52, 8'h48, 8'hff, 8'h00};
        out_ready[D16] = 1'b1;
        for (int b = 0; b < 16; b++) begin
            for (int i = 0; i < 16; i++) din[127 - 8*i -: 8] = 8'(b*16 + i);
            run_block(D16, din, 1, "table", got);
            for (int i = 0; i < 16; i++) res[b*16 + i] = got[127 - 8*i -: 8];
            checks++;
            if (got !== model_inv(din)) begin
                errors++;
                $display("[TB] FAIL table block %0d: got %h, expected %h", b, got, model_inv(din));
            end
            tick();
        end
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (res[spot_in[s]] !== spot_out[s]) begin
                errors++;
                $display("[TB] FAIL spot %h: got %h, expected %h", spot_in[s], res[spot_in[s]], spot_out[s]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] din;
        logic [127:0] d0;
        int unstable, lost, rdy;
        din = 128'h52096ad53036a538bf40a39e81f3d7fb;
        unstable = 0;
        lost = 0;
        rdy = 0;
        out_ready[D4] = 1'b0;
        run_block(D4, din, 4, "bp", d0);
        checks++;
        if (d0 !== model_inv(din)) begin
            errors++;
            $display("[TB] FAIL bp data: got %h, expected %h", d0, model_inv(din));
        end
        in_valid[D4] = 1'b1;
        in_data[D4]  = 128'h00112233445566778899aabbccddeeff;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (out_valid[D4] !== 1'b1) lost++;
            if (out_data[D4] !== d0) unstable++;
            if (in_ready[D4] !== 1'b0) rdy++;
        end
        in_valid[D4] = 1'b0;
        checks += 3;
        if (lost != 0) begin
            errors++;
            $display("[TB] FAIL bp out_valid held: dropped in %0d cycles, expected 0", lost);
        end
        if (unstable != 0) begin
            errors++;
            $display("[TB] FAIL bp out_data stable: changed in %0d cycles, expected 0", unstable);
        end
        if (rdy != 0) begin
            errors++;
            $display("[TB] FAIL bp in_ready low: high in %0d cycles, expected 0", rdy);
        end
        out_ready[D4] = 1'b1;
        tick();
        checks += 2;
        if (out_valid[D4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp release out_valid: got %b, expected 0", out_valid[D4]);
        end
        if (in_ready[D4] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp release in_ready: got %b, expected 1", in_ready[D4]);
        end
        tick();
        tick();
        checks++;
        if (out_valid[D4] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp second block accepted: out_valid %b, expected 0", out_valid[D4]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int seen;
        seen = 0;
        out_ready[D1] = 1'b1;
        send(D1, 128'h637c777bf26b6fc53001672bfed7ab76, "rst_mid");
        for (int c = 0; c < 4; c++) tick();
        rst = 1'b1;
        tick();
        checks += 3;
        if (out_valid[D1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid out_valid: got %b, expected 0", out_valid[D1]);
        end
        if (out_data[D1] !== 128'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid out_data: got %h, expected 0", out_data[D1]);
        end
        if (in_ready[D1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid in_ready during rst: got %b, expected 0", in_ready[D1]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready[D1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_mid in_ready after rst: got %b, expected 1", in_ready[D1]);
        end
        for (int c = 0; c < 20; c++) begin
            if (out_valid[D1] !== 1'b0) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("[TB] FAIL rst_mid partial result: out_valid high %0d cycles, expected 0", seen);
        end
        run_block(D1, {16{8'h63}}, 16, "rst_mid_new", got);
        checks++;
        if (got !== 128'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid new block: got %h, expected 0", got);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk [3];
        int acc_t [3];
        int n_in, n_out, cyc;
        logic acc;
        blk = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h0123456789abcdeffedcba9876543210,
                128'hffeeddccbbaa99887766554433221100};
        acc_t = '{0, 0, 0};
        n_in = 0;
        n_out = 0;
        cyc = 0;
        out_ready[D2] = 1'b1;
        in_valid[D2]  = 1'b1;
        in_data[D2]   = blk[0];
        while ((n_in < 3 || n_out < 3) && cyc < 100) begin
            acc = in_valid[D2] && in_ready[D2];
            if (out_valid[D2] === 1'b1 && n_out < 3) begin
                checks++;
                if (out_data[D2] !== model_inv(blk[n_out])) begin
                    errors++;
                    $display("[TB] FAIL b2b block %0d: got %h, expected %h", n_out, out_data[D2],
                             model_inv(blk[n_out]));
                end
                n_out++;
            end
            tick();
            cyc++;
            if (acc) begin
                acc_t[n_in] = cyc;
                n_in++;
                if (n_in < 3) in_data[D2] = blk[n_in];
                else in_valid[D2] = 1'b0;
            end
        end
        in_valid[D2] = 1'b0;
        checks += 4;
        if (n_in != 3) begin
            errors++;
            $display("[TB] FAIL b2b accepted: got %0d, expected 3", n_in);
        end
        if (n_out != 3) begin
            errors++;
            $display("[TB] FAIL b2b delivered: got %0d, expected 3", n_out);
        end
        if (acc_t[1] - acc_t[0] != 10) begin
            errors++;
            $display("[TB] FAIL b2b spacing 0-1: got %0d, expected 10", acc_t[1] - acc_t[0]);
        end
        if (acc_t[2] - acc_t[1] != 10) begin
            errors++;
            $display("[TB] FAIL b2b spacing 1-2: got %0d, expected 10", acc_t[2] - acc_t[1]);
        end
    endtask

`ifdef AES_SBOX_BIDIR_EN
    task automatic test_bidir();
        logic [127:0] got;
        out_ready[D4] = 1'b1;
        mode[D4] = 1'b1;
        run_block(D4, 128'h0, 4, "bidir_fwd", got);
        checks++;
        if (got !== {16{8'h63}}) begin
            errors++;
            $display("[TB] FAIL bidir forward: got %h, expected all 63", got);
        end
        tick();
        mode[D4] = 1'b0;
        run_block(D4, {16{8'h63}}, 4, "bidir_inv", got);
        checks++;
        if (got !== 128'h0) begin
            errors++;
            $display("[TB] FAIL bidir inverse: got %h, expected 0", got);
        end
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b0;
`ifdef AES_SBOX_BIDIR_EN
            mode[k] = 1'b0;
`endif
        end
        build_tables();
        $display("[TB] starting inv_sub_bytes_engine bench");
        test_reset();
        test_single_block();
        test_table();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef AES_SBOX_BIDIR_EN
        test_bidir();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_engine.md
Name: inv_sub_bytes_engine

Overview:
- AES-128 InvSubBytes engine for the decryption datapath, the inverse counterpart of the registered SubBytes S-box.
- Accepts one 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to all 16 bytes, LANES bytes per cycle, through a registered lookup.
- Returns the substituted state over a second valid/ready handshake.
- Sits between InvShiftRows and AddRoundKey in the decryption round.

Parameters:
- LANES, 4, number of inverse S-box lookups per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- IN_VALID  in  1  input state is valid.
- IN_READY  out  1  engine can accept a state.
- IN_DATA  in  128  input state; byte i = IN_DATA[127-8i -: 8], i = 0..15.
- OUT_VALID  out  1  OUT_DATA holds a completed state.
- OUT_READY  in  1  consumer accepts the output.
- OUT_DATA  out  128  substituted state, same byte mapping as IN_DATA.

Behaviour:
- Reset: when rst is high at a clock edge, the FSM goes to IDLE, OUT_VALID=0, OUT_DATA=0 and the group counter is 0. IN_READY=0 while rst is high. Reset overrides every other event.
- Reset mid-operation aborts the block in flight; no partial result is ever presented.
- N = 16/LANES groups. Group g covers bytes g*LANES .. g*LANES+LANES-1.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - IN_READY=1.
  - When IN_VALID && IN_READY at an edge: capture IN_DATA into the working register, grp=0, go to SUB.
- SUB:
  - IN_READY=0.
  - Each edge replaces the bytes of group grp in the working register with InvSBox(byte), then grp increments.
  - At the edge where grp==N-1: go to DONE and set OUT_VALID=1.
  - No stall inside SUB; input signals are ignored.
- DONE:
  - OUT_VALID=1 and OUT_DATA = working register, held stable until the handshake.
  - When OUT_VALID && OUT_READY at an edge: OUT_VALID=0, go to IDLE.
  - IN_READY=0 throughout DONE, so at most one block is in flight.
- Latency: OUT_VALID is high exactly N cycles after the input handshake edge: 4 cycles at LANES=4, 1 cycle at LANES=16, 16 cycles at LANES=1.
- Throughput: one block per N+2 cycles when OUT_READY is held high.
- IN_DATA may change freely after acceptance; the captured copy is used.
- After the output handshake, OUT_DATA keeps its last value; it is don't-care while OUT_VALID=0.
- InvSBox must equal the FIPS-197 inverse table bit-exactly for all 256 inputs. It may be implemented as a table or as inverse affine followed by GF(2^8) inversion.
- grp width is $clog2(N), minimum 1 bit. grp wraps to 0 when leaving SUB.

Optional Feature:
- Macro: AES_SBOX_BIDIR_EN.
- When defined:
  - Adds input port MODE (1 bit): 1 = forward S-box (SubBytes), 0 = inverse S-box.
  - MODE is sampled at the input handshake and held for the whole block; changes after acceptance have no effect.
  - Latency and handshake are unchanged.
- When undefined:
  - The MODE port does not exist and the engine is inverse-only.
  - No forward-table logic is synthesized.

Test Plan:
- Reset then single block, LANES=4: IN_DATA=0x637c777bf26b6fc53001672bfed7ab76 -> OUT_VALID high 4 cycles after acceptance, OUT_DATA=0x000102030405060708090a0b0c0d0e0f.
- Exhaustive table check, LANES=16: 16 blocks covering bytes 0x00..0xff -> each byte matches InvSBox. Spot values: 0x00->0x52, 0x52->0x48, 0x16->0xff, 0x63->0x00.
- Backpressure: OUT_READY=0 for 10 cycles after OUT_VALID -> OUT_DATA stable, IN_READY=0, a second IN_VALID is not accepted; releasing OUT_READY completes the handshake and IN_READY returns to 1 the next cycle.
- Reset mid-SUB, LANES=1: assert rst 5 cycles after acceptance -> OUT_VALID stays 0, OUT_DATA=0, IN_READY=1 one cycle after rst falls; a new block all-0x63 -> all-0x00 after 16 cycles.
- Streaming, LANES=2, OUT_READY tied high: 3 back-to-back blocks -> each accepted 10 cycles apart, outputs in order and correct.
- AES_SBOX_BIDIR_EN defined: MODE=1 with IN_DATA all-0x00 -> all-0x63; MODE=0 with all-0x63 -> all-0x00. Toggling MODE mid-block has no effect.
